// File: rtl/stream_out_framer.sv
// stream_out_framer: 2-entry output skid buffer that regenerates AXI-Stream
// frame markers (tuser = SOF, tlast = EOL) from its own column/row counters
// and pulses frame_done when the last pixel of the frame leaves the block.
// Optional feature macro: STREAM_OUT_FRAMER_TLAST_CHECK_EN -- when defined,
// upstream tlast is compared against the computed end-of-line and any
// disagreement sets the sticky err_tlast flag.
module stream_out_framer #(
  parameter int DATA_WIDTH = 24,
  parameter int IMG_WIDTH  = 3840,
  parameter int IMG_HEIGHT = 2160
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tlast,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tlast,
  output logic                  m_axis_tuser,
  output logic                  frame_busy,
  output logic                  frame_done,
  output logic                  err_tlast
);

  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic                  sof;
    logic                  eol;
    logic                  eof;
  } beat_t;

  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  beat_t [1:0]   buf_q;
  logic          wr_q, rd_q;
  logic [1:0]    cnt_q, cnt_d;
  logic          rdy_q;   // holds tready low while in reset
  logic          busy_q, done_q;
  logic          push, pop;
  beat_t         in_beat, head;

  assign s_axis_tready = rdy_q && (cnt_q != 2'd2);
  assign m_axis_tvalid = (cnt_q != 2'd0);
  assign push          = s_axis_tvalid && s_axis_tready;
  assign pop           = m_axis_tvalid && m_axis_tready;
  assign head          = buf_q[rd_q];

  assign m_axis_tdata  = head.data;
  assign m_axis_tlast  = head.eol;
  assign m_axis_tuser  = head.sof;
  assign frame_busy    = busy_q;
  assign frame_done    = done_q;

  // Tag the incoming beat from the current position and compute next position
  always_comb begin
    in_beat.data = s_axis_tdata;
    in_beat.sof  = (col_q == '0) && (row_q == '0);
    in_beat.eol  = (col_q == COL_LAST);
    in_beat.eof  = in_beat.eol && (row_q == ROW_LAST);
    col_d = col_q + 1'b1;
    row_d = row_q;
    if (in_beat.eol) begin
      col_d = '0;
      row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
    end
  end

  // Occupancy: push and pop together leave the count unchanged
  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Counters, buffer storage, pointers and frame status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      buf_q  <= '0;
      wr_q   <= 1'b0;
      rd_q   <= 1'b0;
      cnt_q  <= 2'd0;
      rdy_q  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      rdy_q <= 1'b1;
      cnt_q <= cnt_d;
      if (push) begin
        buf_q[wr_q] <= in_beat;
        wr_q        <= ~wr_q;
        col_q       <= col_d;
        row_q       <= row_d;
      end
      if (pop) rd_q <= ~rd_q;
      // A new SOF wins over the previous frame's EOF leaving in the same cycle
      if (push && in_beat.sof)   busy_q <= 1'b1;
      else if (pop && head.eof)  busy_q <= 1'b0;
      done_q <= pop && head.eof;
    end
  end

`ifdef STREAM_OUT_FRAMER_TLAST_CHECK_EN
  logic err_q;

  // Sticky flag: upstream tlast disagreed with our own end-of-line position
  always_ff @(posedge clk) begin
    if (rst)                                     err_q <= 1'b0;
    else if (push && (s_axis_tlast != in_beat.eol)) err_q <= 1'b1;
  end

  assign err_tlast = err_q;
`else
  logic unused_tlast;
  assign unused_tlast = s_axis_tlast;
  assign err_tlast    = 1'b0;
`endif

endmodule

// File: tb/tb_stream_out_framer.sv
module tb_stream_out_framer;
  localparam int DW = 24, W = 4, H = 2, BW = 3840, BH = 2;
  localparam int BIG_BEATS = BW * BH;
`ifdef STREAM_OUT_FRAMER_TLAST_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // small-image DUT
  logic rst = 1'b1, s_valid = 1'b0, s_last = 1'b0, m_ready = 1'b1;
  logic [DW-1:0] s_data = '0, m_data;
  logic s_ready, m_valid, m_last, m_user, busy, done, err;

  stream_out_framer #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tvalid(s_valid), .s_axis_tready(s_ready), .s_axis_tdata(s_data), .s_axis_tlast(s_last),
    .m_axis_tvalid(m_valid), .m_axis_tready(m_ready), .m_axis_tdata(m_data),
    .m_axis_tlast(m_last), .m_axis_tuser(m_user),
    .frame_busy(busy), .frame_done(done), .err_tlast(err));

  // full-width DUT for the random handshake run
  logic b_rst = 1'b1, b_svalid = 1'b0, b_slast = 1'b0, b_mready = 1'b0;
  logic [DW-1:0] b_sdata = '0, b_mdata;
  logic b_sready, b_mvalid, b_mlast, b_muser, b_busy, b_done, b_err;

  stream_out_framer #(.DATA_WIDTH(DW), .IMG_WIDTH(BW), .IMG_HEIGHT(BH)) dut_big (
    .clk(clk), .rst(b_rst),
    .s_axis_tvalid(b_svalid), .s_axis_tready(b_sready), .s_axis_tdata(b_sdata), .s_axis_tlast(b_slast),
    .m_axis_tvalid(b_mvalid), .m_axis_tready(b_mready), .m_axis_tdata(b_mdata),
    .m_axis_tlast(b_mlast), .m_axis_tuser(b_muser),
    .frame_busy(b_busy), .frame_done(b_done), .err_tlast(b_err));

  int tests = 0, fails = 0;

  // scoreboard for the small DUT
  typedef struct packed {
    logic [DW-1:0] d;
    logic sof, eol, eof;
  } exp_t;
  exp_t q[$];
  int mc = 0, mr = 0;
  bit e_busy = 0, e_done = 0, e_err = 0, e_rdy = 0;
  int done_cnt = 0, user_cnt = 0, last_cnt = 0, acc_cnt = 0;

  // Model runs on the falling edge: check registered state, then predict
  // what the upcoming rising edge will do.
  always @(negedge clk) begin
    exp_t h, nb;
    bit pop_eof, push_sof;
    if (rst) begin
      q.delete(); mc = 0; mr = 0;
      e_busy = 0; e_done = 0; e_err = 0; e_rdy = 0;
    end else begin
      tests++;
      if (s_ready !== (e_rdy && q.size() != 2)) begin
        fails++; $display("FAIL sb_s_ready got %b exp %b", s_ready, (e_rdy && q.size() != 2));
      end
      tests++;
      if (m_valid !== (q.size() != 0)) begin
        fails++; $display("FAIL sb_m_valid got %b exp %b", m_valid, (q.size() != 0));
      end
      tests++;
      if (done !== e_done) begin fails++; $display("FAIL sb_frame_done got %b exp %b", done, e_done); end
      tests++;
      if (busy !== e_busy) begin fails++; $display("FAIL sb_frame_busy got %b exp %b", busy, e_busy); end
      tests++;
      if (err !== e_err) begin fails++; $display("FAIL sb_err_tlast got %b exp %b", err, e_err); end
      if (done === 1'b1) done_cnt++;
      pop_eof = 0; push_sof = 0;
      if (m_valid === 1'b1 && q.size() != 0) begin
        h = q[0];
        tests++;
        if ({m_data, m_user, m_last} !== {h.d, h.sof, h.eol}) begin
          fails++;
          $display("FAIL sb_head got d=%h u=%b l=%b exp d=%h u=%b l=%b",
                   m_data, m_user, m_last, h.d, h.sof, h.eol);
        end
        if (m_ready) begin
          void'(q.pop_front());
          pop_eof = h.eof;
          if (h.sof) user_cnt++;
          if (h.eol) last_cnt++;
        end
      end
      if (s_valid && s_ready === 1'b1) begin
        nb.d   = s_data;
        nb.sof = (mc == 0 && mr == 0);
        nb.eol = (mc == W - 1);
        nb.eof = nb.eol && (mr == H - 1);
        if (CHK && s_last !== nb.eol) e_err = 1;
        q.push_back(nb);
        acc_cnt++;
        if (nb.eol) begin mc = 0; mr = (mr == H - 1) ? 0 : mr + 1; end
        else mc++;
        push_sof = nb.sof;
      end
      e_done = pop_eof;
      if (push_sof) e_busy = 1;
      else if (pop_eof) e_busy = 0;
      e_rdy = 1;
    end
  end

  // Present n beats (data base+i), holding each until accepted; beat index
  // 'bad' gets an inverted tlast.
  task automatic send(input int n, input logic [DW-1:0] base, input int bad);
    int i = 0, guard = 0;
    while (i < n && guard < 200) begin
      s_valid = 1'b1;
      s_data  = base + DW'(i);
      s_last  = (mc == W - 1) ^ (i == bad);
      @(negedge clk);
      if (s_ready === 1'b1) i++;
      @(posedge clk); #1;
      guard++;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (i < n) begin
      tests++; fails++; $display("FAIL send_timeout accepted %0d of %0d", i, n);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle(2);
    @(negedge clk);
    tests++;
    if ({s_ready, m_valid, m_data, m_last, m_user, busy, done, err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs got rdy=%b v=%b d=%h l=%b u=%b busy=%b done=%b err=%b",
               s_ready, m_valid, m_data, m_last, m_user, busy, done, err);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    idle(1);
    @(negedge clk);
    tests++;
    if (s_ready !== 1'b1) begin fails++; $display("FAIL reset_ready_rise got %b exp 1", s_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_stream();
    int d0 = done_cnt, u0 = user_cnt, l0 = last_cnt;
    m_ready = 1'b1;
    send(8, 24'h000001, -1);
    idle(3);
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL stream_done_pulses got %0d exp 1", done_cnt - d0); end
    tests++;
    if (user_cnt - u0 !== 1) begin fails++; $display("FAIL stream_tuser got %0d exp 1", user_cnt - u0); end
    tests++;
    if (last_cnt - l0 !== 2) begin fails++; $display("FAIL stream_tlast got %0d exp 2", last_cnt - l0); end
  endtask

  task automatic test_backpressure();
    int a0 = acc_cnt, d0 = done_cnt;
    m_ready = 1'b0;
    fork
      send(3, 24'h000010, -1);
    join_none
    idle(6);
    @(negedge clk);
    tests++;
    if (acc_cnt - a0 !== 2) begin fails++; $display("FAIL bp_absorbed got %0d exp 2", acc_cnt - a0); end
    tests++;
    if (s_ready !== 1'b0) begin fails++; $display("FAIL bp_ready_low got %b exp 0", s_ready); end
    tests++;
    if (m_data !== 24'h000010) begin fails++; $display("FAIL bp_head got %h exp 000010", m_data); end
    @(posedge clk); #1;
    m_ready = 1'b1;
    wait fork;
    send(5, 24'h000013, -1);
    idle(3);
    tests++;
    if (acc_cnt - a0 !== 8) begin fails++; $display("FAIL bp_total got %0d exp 8", acc_cnt - a0); end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL bp_done got %0d exp 1", done_cnt - d0); end
  endtask

  task automatic test_back_to_back();
    int d0 = done_cnt, u0 = user_cnt;
    send(16, 24'h000100, -1);
    idle(3);
    tests++;
    if (done_cnt - d0 !== 2) begin fails++; $display("FAIL b2b_done got %0d exp 2", done_cnt - d0); end
    tests++;
    if (user_cnt - u0 !== 2) begin fails++; $display("FAIL b2b_tuser got %0d exp 2", user_cnt - u0); end
  endtask

  task automatic test_mid_reset_tlast();
    int d0;
    send(5, 24'h000200, -1);
    rst = 1'b1;
    idle(1);
    @(negedge clk);
    tests++;
    if ({m_valid, m_data, m_last, m_user, busy, done, err, s_ready} !== '0) begin
      fails++;
      $display("FAIL midrst_outputs got v=%b d=%h l=%b u=%b busy=%b done=%b err=%b rdy=%b",
               m_valid, m_data, m_last, m_user, busy, done, err, s_ready);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    d0 = done_cnt;
    idle(1);
    send(1, 24'h000300, -1);
    @(negedge clk);
    tests++;
    if ({m_valid, m_user, m_data} !== {1'b1, 1'b1, 24'h000300}) begin
      fails++; $display("FAIL midrst_sof got v=%b u=%b d=%h exp v=1 u=1 d=000300", m_valid, m_user, m_data);
    end
    @(posedge clk); #1;
    send(7, 24'h000301, 1);   // third beat of the frame carries a bogus tlast
    idle(3);
    tests++;
    if (err !== CHK) begin fails++; $display("FAIL tlast_err got %b exp %b", err, CHK); end
    tests++;
    if (done_cnt - d0 !== 1) begin fails++; $display("FAIL midrst_done got %0d exp 1", done_cnt - d0); end
    idle(4);
    tests++;
    if (err !== CHK) begin fails++; $display("FAIL tlast_err_hold got %b exp %b", err, CHK); end
    rst = 1'b1;
    idle(2);
    tests++;
    if (err !== 1'b0) begin fails++; $display("FAIL tlast_err_clear got %b exp 0", err); end
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_random();
    int sent = 0, rcv = 0, lastn = 0, usern = 0, donen = 0, cyc = 0, tail = 0;
    b_rst = 1'b1;
    idle(3);
    b_rst = 1'b0;
    while ((rcv < BIG_BEATS || tail < 3) && cyc < 60000) begin
      b_mready = ($urandom_range(0, 3) != 0);
      b_svalid = (sent < BIG_BEATS) && ($urandom_range(0, 3) != 0);
      b_sdata  = DW'(sent);
      @(negedge clk);
      if (b_done === 1'b1) donen++;
      if (b_mvalid === 1'b1 && b_mready) begin
        tests++;
        if (b_mdata !== DW'(rcv)) begin
          fails++; $display("FAIL rand_data got %h exp %h", b_mdata, DW'(rcv));
        end
        if (b_mlast === 1'b1) lastn++;
        if (b_muser === 1'b1) usern++;
        rcv++;
      end
      if (b_svalid && b_sready === 1'b1) sent++;
      if (rcv >= BIG_BEATS) tail++;
      @(posedge clk); #1;
      cyc++;
    end
    b_svalid = 1'b0;
    b_mready = 1'b0;
    tests++;
    if (rcv !== BIG_BEATS) begin fails++; $display("FAIL rand_count got %0d exp %0d", rcv, BIG_BEATS); end
    tests++;
    if (lastn !== 2) begin fails++; $display("FAIL rand_tlast got %0d exp 2", lastn); end
    tests++;
    if (usern !== 1) begin fails++; $display("FAIL rand_tuser got %0d exp 1", usern); end
    tests++;
    if (donen !== 1) begin fails++; $display("FAIL rand_done got %0d exp 1", donen); end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_stream();
    test_backpressure();
    test_back_to_back();
    test_mid_reset_tlast();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/stream_out_framer.md
# stream_out_framer

- Sits directly downstream of the access-control output stream and feeds the output AXI-Stream master port.
- Registers each accepted pixel beat in a 2-entry buffer and regenerates frame markers: tuser on the first pixel of a frame, tlast on the last pixel of each line.
- Pulses a frame-done strobe when the final pixel of the destination image leaves the block.
- Optionally cross-checks the upstream tlast against its own line count.

## Interface

Parameters:
- DATA_WIDTH, 24: pixel beat width (AXISOUT_DATA_WIDTH).
- IMG_WIDTH, 3840: pixels per line (DST_IMG_WIDTH), ≥ 2.
- IMG_HEIGHT, 2160: lines per frame (DST_IMG_HEIGHT), ≥ 1.

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, rising edge.
- rst  in  1  synchronous active-high reset.
- s_axis_tvalid  in  1  upstream beat valid.
- s_axis_tready  out  1  block can accept a beat.
- s_axis_tdata  in  DATA_WIDTH  upstream pixel.
- s_axis_tlast  in  1  upstream end-of-line marker; used only for checking.
- m_axis_tvalid  out  1  output beat valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output pixel.
- m_axis_tlast  out  1  last pixel of a line.
- m_axis_tuser  out  1  first pixel of a frame (SOF).
- frame_busy  out  1  high from the first accepted pixel until the frame's last output handshake.
- frame_done  out  1  one-cycle pulse after the frame's last output handshake.
- err_tlast  out  1  sticky upstream-tlast mismatch flag.

## Operation

- Input acceptance: an input beat is accepted when s_axis_tvalid && s_axis_tready.
- Counters: col counter is $clog2(IMG_WIDTH) bits; row counter is $clog2(IMG_HEIGHT) bits (minimum 1 bit). Both start at 0.
- Counter advance on each accepted input beat:
  - col increments.
  - col == IMG_WIDTH-1: col wraps to 0 and row increments.
  - row == IMG_HEIGHT-1 and col == IMG_WIDTH-1: row wraps to 0.
- Tags computed at acceptance and stored alongside the data:
  - sof = (row==0 && col==0).
  - eol = (col==IMG_WIDTH-1).
  - eof = eol && row==IMG_HEIGHT-1.
- Buffer: 2-entry FIFO of {data, sof, eol, eof}, with write and read pointers of 1 bit each and a 2-bit count.
  - m_axis_tvalid = (count != 0).
  - m_axis_tdata, m_axis_tlast and m_axis_tuser come from the head entry.
  - s_axis_tready = (count != 2).
- Simultaneous push and pop: count is unchanged. Push into a full buffer cannot occur because tready is low. Pop from an empty buffer cannot occur because tvalid is low.
- Output contract: m_axis_tvalid stays high and the head entry stays stable until m_axis_tready.
- frame_busy:
  - Set on acceptance of an sof beat.
  - Cleared on the output handshake of an eof beat.
  - If an sof is accepted in the same cycle as an eof handshake, frame_busy stays 1.
- frame_done: registered pulse, 1 in the cycle after the eof output handshake, 0 otherwise.
- err_tlast: see Configuration.
- Reset (including mid-frame):
  - Counters clear to 0 and the buffer empties.
  - All outputs go to 0; s_axis_tready goes to 0 during reset and rises to 1 in the first cycle after rst deasserts.
  - Partially transferred frames are discarded with no frame_done pulse.

## Timing

- Latency: a beat accepted at edge N is visible on m_axis at cycle N+1, provided the buffer was empty.
- Throughput: sustained 1 beat/cycle when m_axis_tready is held high.
- Backpressure: with m_axis_tready low, the block absorbs 2 beats and then drops s_axis_tready. s_axis_tready rises again the cycle after the first output handshake.
- Registered outputs: all outputs come from flops except s_axis_tready and m_axis_tvalid, which are decodes of the count register only (no combinational path from input ports).
- frame_done: asserted exactly 1 cycle after the eof handshake, and only for 1 cycle.

## Configuration

- Macro: STREAM_OUT_FRAMER_TLAST_CHECK_EN.
- Defined:
  - On each accepted beat, if s_axis_tlast != computed eol, err_tlast is set to 1 at the next edge.
  - err_tlast holds until rst.
  - Data flow and generated markers are unaffected; the computed eol always drives m_axis_tlast.
- Undefined:
  - s_axis_tlast is ignored.
  - err_tlast is tied to 0 and no comparison logic is built.

## Test plan

All scenarios use IMG_WIDTH=4, IMG_HEIGHT=2 unless noted.
- Streaming frame: 8 beats 0x000001..0x000008 with m_axis_tready=1.
  - Output equals input, each one cycle later.
  - tuser only on 0x000001; tlast on 0x000004 and 0x000008.
  - frame_done pulses once, 1 cycle after 0x000008; frame_busy is high over that span.
- Backpressure: m_axis_tready=0 while pushing 3 beats.
  - s_axis_tready drops after 2 accepts; the third beat waits.
  - Raise tready: order is preserved, no loss or duplication, and the head is stable while stalled.
- Back-to-back frames: 16 continuous beats.
  - tuser on beats 1 and 9.
  - frame_done pulses after beats 8 and 16.
  - frame_busy never drops between the frames.
- Mid-frame reset: rst for 1 cycle after 5 beats.
  - The buffer and all outputs go to 0 with no frame_done.
  - The next beat accepted after reset carries tuser=1.
- Tlast check, macro defined: drive s_axis_tlast=1 on beat 3.
  - err_tlast=1 from the next cycle and holds until rst.
  - With the macro undefined, the same stimulus gives err_tlast=0 and identical m_axis output.
- Random handshakes with IMG_WIDTH=3840, IMG_HEIGHT=2: random valid/ready over 7680 beats.
  - Exactly 2 tlast beats, 1 tuser beat and 1 frame_done pulse.
